dmux_stream: RTL and testbench

Parametrised, registered N-way stream demultiplexer: one valid/ready input stream is routed to one of N output channels chosen by a per-word select, through a single-entry output register with full backpressure. It generalises the combinational 8-way demux to arbitrary word width and channel count and adds handshaking, buffering and error reporting. It sits between a word producer (Hack CPU/memory side, 16-bit words) and N independent consumers.

---
 rtl/dmux_stream_pkg.sv | 19 +
 rtl/dmux_stream_if.sv | 29 ++
 rtl/dmux_stream_sat_counter.sv | 16 +
 rtl/dmux_stream.sv | 78 +++++++
 tb/tb_dmux_stream.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared types and defaults for the dmux_stream block.
// Optional DMUX_STREAM_COUNT_EN adds per-channel drain counters.
package dmux_stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 8;

    // Select width for an N-way demux; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmux_stream_if.sv
// Stream bundle for dmux_stream: one input stream fanning out to N channels.
// slave is the demux side, master is the producer/consumer environment side.
interface dmux_stream_if
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
);
    localparam int SEL_W = sel_width(N);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [WIDTH-1:0] out_data;
    logic             err_sel;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_sel
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_sel
    );
endinterface

// File: rtl/dmux_stream_sat_counter.sv
// Saturating up-counter with synchronous reset, one per output channel.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/dmux_stream.sv
// Registered N-way stream demux with a single-entry output register.
// Define DMUX_STREAM_COUNT_EN to get per-channel saturating drain counters.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    dmux_stream_if.slave            s,
    input  logic [sel_width(N)-1:0] cnt_sel,
    output logic [CNT_W-1:0]        cnt_value
);
    localparam int SEL_W = sel_width(N);

    state_t           state;
    logic [SEL_W-1:0] hold_sel;
    logic [WIDTH-1:0] hold_data;
    logic             err_q;

    logic full, drain, accept, sel_ok;

    assign full   = (state == FULL);
    assign drain  = full && s.out_ready[hold_sel];
    // in_ready must never look at in_valid, so it depends only on state and the held channel's ready.
    assign s.in_ready = !full || s.out_ready[hold_sel];
    assign accept = s.in_valid && s.in_ready;
    assign sel_ok = (int'(s.in_sel) < N);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            hold_sel  <= '0;
            hold_data <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept && !sel_ok;
            if (accept && sel_ok) begin
                state     <= FULL;
                hold_sel  <= s.in_sel;
                hold_data <= s.in_data;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

    always_comb begin
        s.out_valid = '0;
        if (full)
            s.out_valid[hold_sel] = 1'b1;
    end

    assign s.out_data = hold_data;
    assign s.err_sel  = err_q;

`ifdef DMUX_STREAM_COUNT_EN
    logic [N-1:0][CNT_W-1:0] cnt;

    for (genvar k = 0; k < N; k++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (drain && (hold_sel == SEL_W'(k))),
            .count (cnt[k])
        );
    end

    assign cnt_value = (int'(cnt_sel) < N) ? cnt[cnt_sel] : '0;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_value      = '0;
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: an N=8 instance driven from a vector table
// and an N=5, CNT_W=2 instance for out-of-range selects and counter saturation.
module tb_dmux_stream;
    import dmux_stream_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmux_stream_if #(.WIDTH(16), .N(8)) a ();
    dmux_stream_if #(.WIDTH(16), .N(5)) b ();

    logic [2:0] cs_a, cs_b;
    logic [7:0] cv_a;
    logic [1:0] cv_b;

    dmux_stream #(.WIDTH(16), .N(8), .CNT_W(8)) u8 (
        .clk(clk), .reset(reset), .s(a), .cnt_sel(cs_a), .cnt_value(cv_a)
    );
    dmux_stream #(.WIDTH(16), .N(5), .CNT_W(2)) u5 (
        .clk(clk), .reset(reset), .s(b), .cnt_sel(cs_b), .cnt_value(cv_b)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [2:0]  sel;
        logic [7:0]  rdy;
        logic        xir;
        logic [7:0]  xov;
        logic [15:0] xod;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic v, logic [15:0] d, logic [2:0] sel, logic [7:0] rdy,
                                logic xir, logic [7:0] xov, logic [15:0] xod);
        vec_t t;
        t.v = v; t.d = d; t.sel = sel; t.rdy = rdy;
        t.xir = xir; t.xov = xov; t.xod = xod;
        return t;
    endfunction

    // in_ready is checked before the edge, registered outputs after it.
    task automatic apply_a(input vec_t t, input int idx);
        a.in_valid = t.v; a.in_data = t.d; a.in_sel = t.sel; a.out_ready = t.rdy;
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(a.in_ready), 32'(t.xir));
        @(posedge clk); #1;
        chk($sformatf("v%0d out_valid", idx), 32'(a.out_valid), 32'(t.xov));
        chk($sformatf("v%0d out_data", idx), 32'(a.out_data), 32'(t.xod));
        chk($sformatf("v%0d err_sel", idx), 32'(a.err_sel), 32'd0);
    endtask

    task automatic step_b(input logic v, input logic [15:0] d, input logic [2:0] sel);
        b.in_valid = v; b.in_data = d; b.in_sel = sel; b.out_ready = '1;
        @(posedge clk); #1;
    endtask

    logic [1:0] exp_b1, exp_b4;
    logic [7:0] exp_a3;

    initial begin
        a.in_valid = 0; a.in_data = '0; a.in_sel = '0; a.out_ready = '1;
        b.in_valid = 0; b.in_data = '0; b.in_sel = '0; b.out_ready = '1;
        cs_a = 3'd0; cs_b = 3'd0;

        // Single word to channel 3, then idle.
        tv.push_back(mk(1, 16'hA5A5, 3, 8'hFF, 1, 8'h08, 16'hA5A5));
        tv.push_back(mk(0, 16'h0000, 0, 8'hFF, 1, 8'h00, 16'hA5A5));
        // Back-to-back stream walking all channels.
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(1, 16'h1000 + 16'(i), 3'(i), 8'hFF, 1, 8'(1 << i), 16'h1000 + 16'(i)));
        tv.push_back(mk(0, 16'h0000, 0, 8'hFF, 1, 8'h00, 16'h1007));
        // Channel 5 stalls for four cycles while other channels are ready.
        tv.push_back(mk(1, 16'hBEEF, 5, 8'hFF, 1, 8'h20, 16'hBEEF));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1, 16'h1111, 0, 8'hDF, 0, 8'h20, 16'hBEEF));
        tv.push_back(mk(0, 16'h0000, 0, 8'hFF, 1, 8'h00, 16'hBEEF));
        // Stall then release with a new word waiting: drain and accept together.
        tv.push_back(mk(1, 16'h7777, 7, 8'hFF, 1, 8'h80, 16'h7777));
        tv.push_back(mk(1, 16'h6666, 6, 8'h7F, 0, 8'h80, 16'h7777));
        tv.push_back(mk(1, 16'h6666, 6, 8'h80, 1, 8'h40, 16'h6666));
        tv.push_back(mk(0, 16'h0000, 0, 8'hFF, 1, 8'h00, 16'h6666));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst out_valid", 32'(a.out_valid), 32'd0);
        chk("rst out_data", 32'(a.out_data), 32'd0);
        chk("rst err_sel", 32'(a.err_sel), 32'd0);
        chk("rst in_ready", 32'(a.in_ready), 32'd1);
        chk("rst5 out_valid", 32'(b.out_valid), 32'd0);

        foreach (tv[i]) apply_a(tv[i], i);

        // Reset while holding a word for channel 2 overrides a concurrent accept.
        apply_a(mk(1, 16'h2222, 2, 8'h00, 1, 8'h04, 16'h2222), 100);
        reset = 1'b1; a.in_valid = 1; a.in_data = 16'h4444; a.in_sel = 3'd4; a.out_ready = '1;
        @(posedge clk); #1;
        reset = 1'b0; a.in_valid = 0;
        #1;
        chk("rstfull out_valid", 32'(a.out_valid), 32'd0);
        chk("rstfull out_data", 32'(a.out_data), 32'd0);
        chk("rstfull in_ready", 32'(a.in_ready), 32'd1);
        chk("rst5 out_data", 32'(b.out_data), 32'd0);

        // N=5: select 6 is dropped, err_sel pulses exactly one cycle.
        @(negedge clk);
        b.in_valid = 1; b.in_data = 16'h1234; b.in_sel = 3'd6; b.out_ready = '1;
        #1 chk("n5 in_ready", 32'(b.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("n5 drop out_valid", 32'(b.out_valid), 32'd0);
        chk("n5 drop err_sel", 32'(b.err_sel), 32'd1);
        chk("n5 drop out_data", 32'(b.out_data), 32'd0);
        step_b(0, 16'h0000, 3'd0);
        chk("n5 err pulse end", 32'(b.err_sel), 32'd0);
        chk("n5 empty in_ready", 32'(b.in_ready), 32'd1);

        // Top channel of N=5, then an out-of-range word while draining it.
        step_b(1, 16'h4321, 3'd4);
        chk("n5 ch4 out_valid", 32'(b.out_valid), 32'h10);
        chk("n5 ch4 out_data", 32'(b.out_data), 32'h4321);
        chk("n5 ch4 err_sel", 32'(b.err_sel), 32'd0);
        step_b(1, 16'hDEAD, 3'd7);
        chk("n5 drop+drain out_valid", 32'(b.out_valid), 32'd0);
        chk("n5 drop+drain err_sel", 32'(b.err_sel), 32'd1);
        chk("n5 drop+drain out_data", 32'(b.out_data), 32'h4321);

        // Five drains to channel 1 saturate a 2-bit counter.
        for (int i = 0; i < 5; i++) step_b(1, 16'h0100 + 16'(i), 3'd1);
        step_b(0, 16'h0000, 3'd0);
        chk("n5 after drains out_valid", 32'(b.out_valid), 32'd0);
        chk("n5 last out_data", 32'(b.out_data), 32'h0104);

`ifdef DMUX_STREAM_COUNT_EN
        exp_b1 = 2'd3; exp_b4 = 2'd1; exp_a3 = 8'd2;
`else
        exp_b1 = 2'd0; exp_b4 = 2'd0; exp_a3 = 8'd0;
`endif
        // The N=8 reset above cleared its counters, so drive two fresh drains to channel 3.
        a.in_valid = 1; a.in_data = 16'h3333; a.in_sel = 3'd3; a.out_ready = '1;
        repeat (2) @(posedge clk);
        #1 a.in_valid = 0;
        @(posedge clk); #1;

        cs_b = 3'd1; #1 chk("cnt ch1", 32'(cv_b), 32'(exp_b1));
        cs_b = 3'd0; #1 chk("cnt ch0", 32'(cv_b), 32'd0);
        cs_b = 3'd4; #1 chk("cnt ch4", 32'(cv_b), 32'(exp_b4));
        cs_a = 3'd3; #1 chk("cnt8 ch3", 32'(cv_a), 32'(exp_a3));
        cs_a = 3'd5; #1 chk("cnt8 ch5", 32'(cv_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
